// File: rtl/mmu_pkg.sv
// Shared types and defaults for the sample-memory management unit.
package mmu_pkg;
  typedef logic [31:0] word_t;
  localparam int DEFAULT_DEPTH = 1024;
endpackage

// File: rtl/mmu_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Storage and read register carry no reset so the array maps onto block RAM.
module mmu_ram
  import mmu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mmu.sv
// Circular capture buffer: stores samples as they arrive, reads back newest-first.
// A write re-arms the read cursor onto the word just stored.
module mmu
  import mmu_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic  clk_i,
  input  logic  rst_in,
  input  logic  mem_wrt_i,
  input  logic  mem_read_i,
  input  word_t mem_i,
  output word_t mem_o
);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rd_en;
  logic          rd_seen;
  word_t         rdata;

  // Write wins a collision; the read strobe is dropped outright.
  assign rd_en = mem_read_i & ~mem_wrt_i;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '1;
      rd_seen <= 1'b0;
    end else if (mem_wrt_i) begin
      wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= wr_ptr;
    end else if (rd_en) begin
      rd_ptr  <= rd_ptr - AW'(1);
      rd_seen <= 1'b1;
    end
  end

  mmu_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk_i),
    .we    (mem_wrt_i),
    .waddr (wr_ptr),
    .wdata (mem_i),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // The RAM read register has no reset; mask it to zero until the first read
  // after reset so mem_o clears asynchronously without touching the array.
  assign mem_o = rd_seen ? rdata : '0;

endmodule

// File: tb/tb_mmu.sv
// Directed self-checking bench for mmu with an 8-word buffer.
module tb_mmu;
  import mmu_pkg::*;

  localparam int DEPTH           = 8;
  localparam int CLK_PERIOD_HALF = 5;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  wrt = 1'b0;
  logic  rd = 1'b0;
  word_t din = '0;
  word_t dout;

  int n_chk = 0;
  int n_fail = 0;

  mmu #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_in     (rst_n),
    .mem_wrt_i  (wrt),
    .mem_read_i (rd),
    .mem_i      (din),
    .mem_o      (dout)
  );

  always #CLK_PERIOD_HALF clk = ~clk;

  // Called at a falling edge: drive strobes across one rising edge, return at the next falling edge.
  task automatic cyc(input logic w, input logic r, input word_t d);
    wrt = w; rd = r; din = d;
    @(negedge clk);
    wrt = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    do_reset();
    n_chk++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_mem_o: got %h want %h", dout, 32'h0); end
    cyc(0, 0, '0);
    n_chk++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_idle: got %h want %h", dout, 32'h0); end
    // Fill addresses 0..7 if the first write lands at 0; then reset and read from DEPTH-1 down.
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'hC0 + i);
    do_reset();
    n_chk++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_again: got %h want %h", dout, 32'h0); end
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'hC7) begin n_fail++; $display("FAIL reset_addr7: got %h want %h", dout, 32'hC7); end
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'hC6) begin n_fail++; $display("FAIL reset_addr6: got %h want %h", dout, 32'hC6); end
  endtask

  task automatic test_lifo();
    word_t exp [3];
    exp[0] = 32'h33; exp[1] = 32'h22; exp[2] = 32'h11;
    cyc(1, 0, 32'h11);
    cyc(1, 0, 32'h22);
    cyc(1, 0, 32'h33);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, '0);
      n_chk++;
      if (dout !== exp[i]) begin n_fail++; $display("FAIL lifo_%0d: got %h want %h", i, dout, exp[i]); end
    end
  endtask

  task automatic test_hold();
    cyc(1, 0, 32'hA5A5A5A5);
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL hold_read: got %h want %h", dout, 32'hA5A5A5A5); end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'hFFFF_FFFF);
      n_chk++;
      if (dout !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL hold_idle_%0d: got %h want %h", i, dout, 32'hA5A5A5A5); end
    end
    cyc(1, 0, 32'h1);
    n_chk++;
    if (dout !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL hold_write: got %h want %h", dout, 32'hA5A5A5A5); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, word_t'(i));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 1, '0);
      n_chk++;
      if (dout !== word_t'(9 - i)) begin n_fail++; $display("FAIL wrap_rd_%0d: got %h want %h", i, dout, word_t'(9 - i)); end
    end
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'h9) begin n_fail++; $display("FAIL wrap_revisit: got %h want %h", dout, 32'h9); end
  endtask

  task automatic test_collision();
    cyc(1, 0, 32'hAA);
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'hAA) begin n_fail++; $display("FAIL coll_pre: got %h want %h", dout, 32'hAA); end
    cyc(1, 1, 32'hBB);
    n_chk++;
    if (dout !== 32'hAA) begin n_fail++; $display("FAIL coll_hold: got %h want %h", dout, 32'hAA); end
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'hBB) begin n_fail++; $display("FAIL coll_read: got %h want %h", dout, 32'hBB); end
  endtask

  task automatic test_back_to_back_reset();
    cyc(1, 0, 32'h1);
    cyc(1, 0, 32'h2);
    cyc(1, 0, 32'h3);
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'h3) begin n_fail++; $display("FAIL arst_pre: got %h want %h", dout, 32'h3); end
    rd = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (dout !== 32'h2) begin n_fail++; $display("FAIL arst_burst: got %h want %h", dout, 32'h2); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL arst_async: got %h want %h", dout, 32'h0); end
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if (dout !== 32'h0) begin n_fail++; $display("FAIL arst_release: got %h want %h", dout, 32'h0); end
    cyc(1, 0, 32'h5);
    cyc(0, 1, '0);
    n_chk++;
    if (dout !== 32'h5) begin n_fail++; $display("FAIL arst_after: got %h want %h", dout, 32'h5); end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_hold();
    test_wrap();
    test_collision();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
